cap_count_seq: RTL

CAP_COUNT_SEQ -- requirements
Module: cap_count_seq

---
 rtl/cap_count_if.sv | 32 +++
 rtl/cap_count_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cap_count_if.sv
// Request/result bus of the capacitor-count sequencer.
// The master drives a capacitor-array configuration plus a request; the
// slave answers with the number of active cells.
interface cap_count_if #(
    parameter int N_COL = 16,
    parameter int N_ROW = 16
);
    localparam int CW = $clog2(N_COL * N_ROW + 1);

    logic [N_COL-1:0] col_off;
    logic [N_COL-1:0] col_on;
    logic [N_ROW-1:0] row_p;
    logic [N_ROW-1:0] row_n;
    logic             swap;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    num_cap;
    logic             busy;

    modport master (
        output col_off, col_on, row_p, row_n, swap, in_valid, abort, out_ready,
        input  in_ready, out_valid, num_cap, busy
    );

    modport slave (
        input  col_off, col_on, row_p, row_n, swap, in_valid, abort, out_ready,
        output in_ready, out_valid, num_cap, busy
    );
endinterface

// File: rtl/cap_count_seq.sv
// Capacitor-count sequencer.
// Captures an array configuration on the request handshake, then walks the
// columns COLS_PER_CYC at a time, summing active cells. The result takes
// N_COL/COLS_PER_CYC clock edges and is held until the result handshake.
module cap_count_seq #(
    parameter int N_COL        = 16,
    parameter int N_ROW        = 16,
    parameter int COLS_PER_CYC = 1
) (
    input logic        clk,
    input logic        rst_n,
    cap_count_if.slave bus
);
    localparam int CW = $clog2(N_COL * N_ROW + 1);
    localparam int IW = (N_COL > 2) ? $clog2(N_COL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    acc_q;
    logic [CW-1:0]    num_cap_q;
    logic [IW-1:0]    idx_q;
    logic [N_COL-1:0] col_off_q;
    logic [N_COL-1:0] col_on_q;
    logic [N_ROW-1:0] row_p_q;
    logic [N_ROW-1:0] row_n_q;
    logic             swap_q;

    logic [CW-1:0]    group_sum;
    logic [CW-1:0]    acc_sum;
    logic [IW-1:0]    col;
    logic [N_ROW-1:0] sel;
    logic             is_last;

    // Final group: idx has reached the start of the last COLS_PER_CYC block.
    assign is_last = (idx_q == IW'(N_COL - COLS_PER_CYC));
    assign acc_sum = acc_q + group_sum;

    // Sum the active cells in the column group starting at idx.
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        group_sum = '0;
        col       = '0;
        sel       = '0;
        for (int c = 0; c < COLS_PER_CYC; c++) begin
            col = idx_q + IW'(c);
            // Even columns use row_n and odd columns row_p; swap reverses that.
            sel = (col[0] ^ swap_q) ? row_p_q : row_n_q;
            if (!col_off_q[col]) begin
                group_sum = group_sum + CW'(N_ROW);
            end else if (col_on_q[col]) begin
                for (int r = 0; r < N_ROW; r++) begin
                    if (sel[r]) group_sum = group_sum + CW'(1);
                end
            end
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort overrides the transfer and result handshakes.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.in_valid)  state_d = RUN;
                RUN:     if (is_last)       state_d = DONE;
                DONE:    if (bus.out_ready) state_d = IDLE;
                default:                    state_d = IDLE;
            endcase
        end
    end

    // Datapath: capture on transfer, accumulate in RUN, publish on the last group.
    // NOTE: all datapath registers, including the captured configuration, reset so a
    // request after reset sees exactly the power-up state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            num_cap_q <= '0;
            idx_q     <= '0;
            col_off_q <= '0;
            col_on_q  <= '0;
            row_p_q   <= '0;
            row_n_q   <= '0;
            swap_q    <= 1'b0;
        end else if (bus.abort) begin
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        col_off_q <= bus.col_off;
                        col_on_q  <= bus.col_on;
                        row_p_q   <= bus.row_p;
                        row_n_q   <= bus.row_n;
                        swap_q    <= bus.swap;
                        acc_q     <= '0;
                        idx_q     <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_sum;
                    idx_q <= idx_q + IW'(COLS_PER_CYC);
                    if (is_last) num_cap_q <= acc_sum;
                end
                default: ;
            endcase
        end
    end

    // Status outputs decode straight from the state so reset reaches them immediately.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.num_cap   = num_cap_q;

endmodule
